// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the SDRAM controller.
// The arbiter uses the slave view; requesters and the controller share the master view.
interface sdram_arbiter_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic [DW-1:0] p1_rdata;

  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic          sd_rd;
  logic          sd_we_n;
  logic [DW-1:0] sd_rdata;

  logic          busy;
  logic          grant;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  sd_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output sd_addr, sd_wdata, sd_rd, sd_we_n,
    output busy, grant
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output sd_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  sd_addr, sd_wdata, sd_rd, sd_we_n,
    input  busy, grant
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one flag-less SDRAM controller between two ports:
// a fixed-length command window, then a fixed idle gap so the controller re-arms.
module sdram_arbiter #(
  parameter int AW         = 22,
  parameter int DW         = 16,
  parameter int ACC_CYCLES = 12,
  parameter int GAP_CYCLES = 4
) (
  input  logic           clk50mhz,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);
  localparam int MAXC = (ACC_CYCLES > GAP_CYCLES) ? ACC_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] ACC_LOAD = CW'(ACC_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          op_we, op_we_n;
  logic          win;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic          rd_n, we_n_n, grant_n;
  logic          ack0_n, ack1_n;
  logic [DW-1:0] rdata0_n, rdata1_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_we_n  = op_we;
    addr_n   = bus.sd_addr;
    wdata_n  = bus.sd_wdata;
    rd_n     = bus.sd_rd;
    we_n_n   = bus.sd_we_n;
    grant_n  = bus.grant;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    rdata0_n = bus.p0_rdata;
    rdata1_n = bus.p1_rdata;
    // Port 1 wins when alone, or on a tie when port 0 had the last turn.
    win      = bus.p1_req & (~bus.p0_req | ~bus.grant);

    case (state)
      IDLE: begin
        if (bus.p0_req | bus.p1_req) begin
          grant_n = win;
          addr_n  = win ? bus.p1_addr  : bus.p0_addr;
          wdata_n = win ? bus.p1_wdata : bus.p0_wdata;
          op_we_n = win ? bus.p1_we    : bus.p0_we;
          // A read raises rd with we_n high; a write lowers we_n with rd low.
          rd_n    = ~op_we_n;
          we_n_n  = ~op_we_n;
          cnt_n   = ACC_LOAD;
          state_n = CMD;
        end
      end
      CMD: begin
        if (cnt == '0) begin
          rd_n   = 1'b0;
          we_n_n = 1'b1;
          if (bus.grant) begin
            ack1_n = 1'b1;
            if (!op_we) rdata1_n = bus.sd_rdata;
          end else begin
            ack0_n = 1'b1;
            if (!op_we) rdata0_n = bus.sd_rdata;
          end
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_we        <= 1'b0;
      bus.sd_addr  <= '0;
      bus.sd_wdata <= '0;
      bus.sd_rd    <= 1'b0;
      bus.sd_we_n  <= 1'b1;
      bus.p0_ack   <= 1'b0;
      bus.p1_ack   <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
      bus.busy     <= 1'b0;
      bus.grant    <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      op_we        <= op_we_n;
      bus.sd_addr  <= addr_n;
      bus.sd_wdata <= wdata_n;
      bus.sd_rd    <= rd_n;
      bus.sd_we_n  <= we_n_n;
      bus.p0_ack   <= ack0_n;
      bus.p1_ack   <= ack1_n;
      bus.p0_rdata <= rdata0_n;
      bus.p1_rdata <= rdata1_n;
      bus.busy     <= (state_n != IDLE);
      bus.grant    <= grant_n;
    end
  end
endmodule
